// File: rtl/mat2_pkg.sv
// Shared op codes and width helpers for the 2x2 signed matrix arithmetic unit.
package mat2_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DET = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int W_DEF = 4;

    // Products need 2W bits; one extra bit keeps their difference exact.
    function automatic int rw_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mat2_det_core.sv
// Two-stage determinant shared by DET and INV: registered cross products,
// then a registered difference.
module mat2_det_core
    import mat2_pkg::*;
#(
    parameter int W = W_DEF,
    localparam int RW = rw_width(W),
    localparam int PW = 2 * W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en1,
    input  logic          en2,
    input  logic [W-1:0]  a11,
    input  logic [W-1:0]  a12,
    input  logic [W-1:0]  a21,
    input  logic [W-1:0]  a22,
    output logic [RW-1:0] det
);

    logic signed [PW-1:0] p_main;
    logic signed [PW-1:0] p_anti;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_main <= '0;
            p_anti <= '0;
        end else if (en1) begin
            p_main <= PW'($signed(a11)) * PW'($signed(a22));
            p_anti <= PW'($signed(a12)) * PW'($signed(a21));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det <= '0;
        end else if (en2) begin
            det <= RW'(p_main) - RW'(p_anti);
        end
    end

endmodule

// File: rtl/mat2_arith_unit.sv
// Pipelined 2x2 signed matrix add / determinant / scaled-inverse unit.
// Define MAT2_SUB_EN to make op 11 an element-wise subtract; otherwise op 11 reports err.
module mat2_arith_unit
    import mat2_pkg::*;
#(
    parameter int W = W_DEF,
    localparam int RW = rw_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a11,
    input  logic [W-1:0]  a12,
    input  logic [W-1:0]  a21,
    input  logic [W-1:0]  a22,
    input  logic [W-1:0]  b11,
    input  logic [W-1:0]  b12,
    input  logic [W-1:0]  b21,
    input  logic [W-1:0]  b22,
    output logic          out_valid,
    output logic [RW-1:0] r11,
    output logic [RW-1:0] r12,
    output logic [RW-1:0] r21,
    output logic [RW-1:0] r22,
    output logic [RW-1:0] det,
    output logic          singular,
    output logic          err
);

    logic signed [RW-1:0] ea [4];
    logic signed [RW-1:0] eb [4];
    logic signed [RW-1:0] sum1 [4];
    logic signed [RW-1:0] adj1 [4];
`ifdef MAT2_SUB_EN
    logic signed [RW-1:0] diff1 [4];
`endif
    logic signed [RW-1:0] cand_sel [4];
    logic signed [RW-1:0] cand2 [4];
    logic signed [RW-1:0] res_n [4];
    logic [RW-1:0]        det_full;
    logic [RW-1:0]        det_n;
    logic                 sing_n;
    logic                 err_n;
    logic                 v1, v2;
    logic [1:0]           op1, op2;

    assign ea[0] = RW'($signed(a11));
    assign ea[1] = RW'($signed(a12));
    assign ea[2] = RW'($signed(a21));
    assign ea[3] = RW'($signed(a22));
    assign eb[0] = RW'($signed(b11));
    assign eb[1] = RW'($signed(b12));
    assign eb[2] = RW'($signed(b21));
    assign eb[3] = RW'($signed(b22));

    // Widening before negation keeps -(-2^(W-1)) exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            op1 <= OP_ADD;
            for (int i = 0; i < 4; i++) begin
                sum1[i] <= '0;
                adj1[i] <= '0;
`ifdef MAT2_SUB_EN
                diff1[i] <= '0;
`endif
            end
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                op1 <= op;
                for (int i = 0; i < 4; i++) begin
                    sum1[i] <= ea[i] + eb[i];
`ifdef MAT2_SUB_EN
                    diff1[i] <= ea[i] - eb[i];
`endif
                end
                adj1[0] <= ea[3];
                adj1[1] <= -ea[1];
                adj1[2] <= -ea[2];
                adj1[3] <= ea[0];
            end
        end
    end

    mat2_det_core #(.W(W)) u_det (
        .clk  (clk),
        .rst_n(rst_n),
        .en1  (in_valid),
        .en2  (v1),
        .a11  (a11),
        .a12  (a12),
        .a21  (a21),
        .a22  (a22),
        .det  (det_full)
    );

    always_comb begin
        cand_sel = '{default: '0};
        case (op1)
            OP_ADD:  cand_sel = sum1;
            OP_INV:  cand_sel = adj1;
`ifdef MAT2_SUB_EN
            OP_SUB:  cand_sel = diff1;
`endif
            default: cand_sel = '{default: '0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            op2   <= OP_ADD;
            cand2 <= '{default: '0};
        end else begin
            v2 <= v1;
            if (v1) begin
                op2   <= op1;
                cand2 <= cand_sel;
            end
        end
    end

    // The singular test needs the finished determinant, so it lands in the output stage.
    always_comb begin
        res_n  = '{default: '0};
        det_n  = '0;
        sing_n = 1'b0;
        err_n  = 1'b0;
        case (op2)
            OP_ADD: res_n = cand2;
            OP_DET: det_n = det_full;
            OP_INV: begin
                det_n = det_full;
                if (det_full == '0) begin
                    sing_n = 1'b1;
                end else begin
                    res_n = cand2;
                end
            end
            OP_SUB: begin
`ifdef MAT2_SUB_EN
                res_n = cand2;
`else
                err_n = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r11       <= '0;
            r12       <= '0;
            r21       <= '0;
            r22       <= '0;
            det       <= '0;
            singular  <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                r11      <= res_n[0];
                r12      <= res_n[1];
                r21      <= res_n[2];
                r22      <= res_n[3];
                det      <= det_n;
                singular <= sing_n;
                err      <= err_n;
            end
        end
    end

endmodule

// File: tb/tb_mat2_arith_unit.sv
// Self-checking bench for mat2_arith_unit: directed cases, random traffic and
// mid-pipeline reset, against an integer-arithmetic reference model.
module tb_mat2_arith_unit;

    localparam int W     = 4;
    localparam int RW    = 2 * W + 1;
    localparam int OBS_W = 1 + 5 * RW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a11, a12, a21, a22, b11, b12, b21, b22;
    logic          out_valid;
    logic [RW-1:0] r11, r12, r21, r22, det;
    logic          singular, err;

    int ai [4] = '{0, 0, 0, 0};
    int bi [4] = '{0, 0, 0, 0};

    int vectors = 0;
    int miscompares = 0;

    logic [OBS_W-1:0] obs;
    logic [OBS_W-1:0] expected;
    logic [OBS_W-2:0] last_res = '0;
    logic [OBS_W-1:0] exp_q [$];

    assign a11 = W'(ai[0]);
    assign a12 = W'(ai[1]);
    assign a21 = W'(ai[2]);
    assign a22 = W'(ai[3]);
    assign b11 = W'(bi[0]);
    assign b12 = W'(bi[1]);
    assign b21 = W'(bi[2]);
    assign b22 = W'(bi[3]);
    assign obs = {out_valid, r11, r12, r21, r22, det, singular, err};

    mat2_arith_unit #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .op       (op),
        .a11      (a11),
        .a12      (a12),
        .a21      (a21),
        .a22      (a22),
        .b11      (b11),
        .b12      (b12),
        .b21      (b21),
        .b22      (b22),
        .out_valid(out_valid),
        .r11      (r11),
        .r12      (r12),
        .r21      (r21),
        .r22      (r22),
        .det      (det),
        .singular (singular),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference result of one op, straight from the matrix definitions.
    function automatic logic [OBS_W-2:0] model_result(input logic [1:0] o, input int a [4], input int b [4]);
        int  r [4];
        int  d;
        logic s, e;
        r = '{0, 0, 0, 0};
        d = 0;
        s = 1'b0;
        e = 1'b0;
        case (o)
            2'b00: for (int i = 0; i < 4; i++) r[i] = a[i] + b[i];
            2'b01: d = a[0] * a[3] - a[1] * a[2];
            2'b10: begin
                d = a[0] * a[3] - a[1] * a[2];
                if (d == 0) s = 1'b1;
                else r = '{a[3], -a[1], -a[2], a[0]};
            end
            default: begin
`ifdef MAT2_SUB_EN
                for (int i = 0; i < 4; i++) r[i] = a[i] - b[i];
`else
                e = 1'b1;
`endif
            end
        endcase
        return {RW'(r[0]), RW'(r[1]), RW'(r[2]), RW'(r[3]), RW'(d), s, e};
    endfunction

    task automatic set_op(input logic v, input logic [1:0] o,
                          input int x0, input int x1, input int x2, input int x3,
                          input int y0, input int y1, input int y2, input int y3);
        in_valid = v;
        op = o;
        ai = '{x0, x1, x2, x3};
        bi = '{y0, y1, y2, y3};
    endtask

    task automatic set_idle();
        set_op(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and work out what the outputs should now show.
    task automatic tick();
        logic [OBS_W-1:0] entry;
        entry = {in_valid, model_result(op, ai, bi)};
        @(posedge clk);
        #1;
        exp_q.push_back(entry);
        expected = {1'b0, last_res};
        if (exp_q.size() > 2) begin
            entry = exp_q.pop_front();
            if (entry[OBS_W-1]) begin
                last_res = entry[OBS_W-2:0];
                expected = entry;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_res = '0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, {OBS_W{1'b0}});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs !== expected) begin
                miscompares++;
                $display("[TB] FAIL reset_idle: got %h expected %h", obs, expected);
            end
        end
    endtask

    task automatic test_directed();
        for (int k = 0; k < 10; k++) begin
            case (k)
                0: set_op(1'b1, 2'b00, 3, 2, 1, 4, 1, 1, 1, 1);
                1: set_op(1'b1, 2'b01, 1, 2, 3, 4, 0, 0, 0, 0);
                2: set_op(1'b1, 2'b10, 0, 3, 2, 1, 0, 0, 0, 0);
                3: set_op(1'b1, 2'b10, 2, 4, 1, 2, 0, 0, 0, 0);
                4: set_op(1'b1, 2'b00, -8, 7, -8, 7, -8, 7, -8, 7);
                5: set_op(1'b1, 2'b11, 3, 2, 1, 4, 1, 1, 1, 1);
                6: set_op(1'b1, 2'b10, -8, -8, -8, 7, 0, 0, 0, 0);
                default: set_idle();
            endcase
            tick();
            vectors++;
            if (obs !== expected) begin
                miscompares++;
                $display("[TB] FAIL directed[%0d]: got %h expected %h", k, obs, expected);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            set_op($urandom_range(3) != 0, 2'($urandom_range(3)),
                   int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                   int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                   int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                   int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
            tick();
            vectors++;
            if (obs !== expected) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", k, obs, expected);
            end
        end
        set_idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (obs !== expected) begin
                miscompares++;
                $display("[TB] FAIL random_drain[%0d]: got %h expected %h", k, obs, expected);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_op(1'b1, 2'b00, 3, 2, 1, 4, 1, 1, 1, 1);
        tick();
        set_op(1'b1, 2'b01, 1, 2, 3, 4, 0, 0, 0, 0);
        tick();
        set_op(1'b1, 2'b00, 5, 5, 5, 5, 1, 1, 1, 1);
        tick();
        vectors++;
        if (obs !== expected) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got %h expected %h", obs, expected);
        end
        rst_n = 1'b0;
        model_reset();
        set_idle();
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got %h expected %h", obs, {OBS_W{1'b0}});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (obs !== expected) begin
                miscompares++;
                $display("[TB] FAIL post_reset_stale[%0d]: got %h expected %h", k, obs, expected);
            end
        end
        set_op(1'b1, 2'b10, 0, 3, 2, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            set_idle();
            vectors++;
            if (obs !== expected) begin
                miscompares++;
                $display("[TB] FAIL post_reset_op[%0d]: got %h expected %h", k, obs, expected);
            end
        end
    endtask

    initial begin
        $display("[TB] starting mat2_arith_unit bench");
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
